pit_timer: RTL
==============

Name: pit_timer

Overview:
Programmable interval timer, Wishbone classic slave; a 32-bit down-counter that raises a level interrupt on expiry.
irq_o wires directly to one irq_i line of the 8-input PIC, which edge-detects it and clears its pending bit on the falling edge.
irq_o therefore stays high until software clears the status bit, then returns low. This produces a clean rising/falling pair per event.
Supports one-shot and periodic modes.

Parameters:
RESET_LOAD, 32'd0, reset value of LOAD and COUNT
PRESCALE_W, 8, width of the prescaler field (used only with PIT_PRESCALER_EN)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous, active-low reset
cyc_i  in  1  Wishbone cycle
stb_i  in  1  Wishbone strobe
we_i  in  1  write enable
sel_i  in  4  byte selects; ignored, all accesses are full-word
adr_i  in  32  address; only adr_i[3:2] decoded
dat_i  in  32  write data
dat_o  out  32  read data, registered, valid while ack_o is high
ack_o  out  1  single-cycle acknowledge
irq_o  out  1  level interrupt to the PIC

Behaviour:
- Reset (async, rst_n_i=0): CTRL=0, LOAD=COUNT=RESET_LOAD, STATUS=0, prescaler=0, state=ST_STOP, ack_o=0, dat_o=0, irq_o=0.
- Bus protocol:
  - ack_o rises the cycle after cyc_i&stb_i with ack_o low, and lasts one cycle; a held strobe gives ack every other cycle.
  - A write commits on the ack cycle. Read data is latched into dat_o on the same edge that raises ack_o.
- Register map, adr_i[3:2]:
  - 0 CTRL rw: [0] EN, [1] PERIODIC, [2] IE, [15:8] PRESCALE.
  - 1 LOAD rw: 32-bit reload value.
  - 2 COUNT ro: writes ignored.
  - 3 STATUS: [0] EXPIRED, sticky; write 1 clears; reads have no side effects.
- Tick: one pulse every (PRESCALE+1) clk cycles while in ST_RUN. The prescaler restarts whenever ST_RUN is entered.
- ST_STOP:
  - A CTRL write with EN=1 sets count <= LOAD and moves to ST_RUN; the first tick comes PRESCALE+1 cycles later.
  - A LOAD write also copies the value into COUNT.
- ST_RUN, on each tick:
  - count>1: count <= count-1.
  - count==1: EXPIRED <= 1. If PERIODIC, count <= LOAD and stay in ST_RUN. Otherwise count <= 0, EN <= 0, go to ST_STOP.
  - count==0 (LOAD=0): hold; no expiry ever fires.
- ST_RUN, register writes:
  - A LOAD write does not touch COUNT; the new value applies at the next reload.
  - A CTRL write with EN=0 moves to ST_STOP and freezes COUNT.
  - A CTRL write with EN=1 while already running updates the mode bits only; no restart.
- Period: exactly LOAD*(PRESCALE+1) clk cycles between expiries.
- irq_o is registered: irq_o <= EXPIRED & IE, one cycle after EXPIRED sets.
- Simultaneous expiry and STATUS W1C in the same cycle: set wins, so the event is not lost.
- Clearing IE drops irq_o one cycle later and leaves EXPIRED intact.
- Reset mid-count or mid-bus-cycle: all state clears immediately; no ack is issued for the aborted access.

Optional Feature:
PIT_PRESCALER_EN
- Defined: CTRL[8+:PRESCALE_W] is implemented as described above.
- Undefined: the field reads 0 and writes are ignored; tick fires every clock; no prescaler logic is built.

Decomposition:
- Package pit_pkg holds:
  - register offsets (PIT_CTRL=2'd0, PIT_LOAD=2'd1, PIT_COUNT=2'd2, PIT_STATUS=2'd3);
  - CTRL bit indices;
  - state encoding (ST_STOP, ST_RUN).
- One sub-module, pit_prescaler: inputs clk, rst_n, restart, run, divisor; output a single-cycle tick. It is instantiated only under PIT_PRESCALER_EN.

Test Plan:
- Reset, then read all four registers -> CTRL=0, LOAD=0, COUNT=0, STATUS=0; irq_o=0; each access acked exactly one cycle after strobe.
- LOAD=5, CTRL=0x5 (EN|IE, one-shot, PRESCALE=0) -> COUNT reads 5,4,…; EXPIRED set 5 cycles after the EN write commits; irq_o high 1 cycle later; EN reads 0; COUNT=0; write STATUS=1 -> irq_o low next cycle.
- LOAD=3, CTRL=0x7 (periodic) for 20 cycles -> EXPIRED set every 3 cycles. W1C issued in the expiry cycle -> EXPIRED remains 1.
- With PIT_PRESCALER_EN: LOAD=2, PRESCALE=3, periodic -> expiry every 8 cycles. Without the macro, a PRESCALE write reads back 0 and expiry is every 2 cycles.
- LOAD=0, EN=1 -> no expiry over 100 cycles. In ST_RUN write LOAD=10 -> COUNT unchanged until the next reload; EN=0 write freezes COUNT.
- Assert rst_n_i mid-count with irq_o high -> irq_o, ack_o, COUNT and STATUS go to 0 asynchronously. Wired to PIC irq_i[0]: the PIC sees a rising edge on expiry and a falling edge after W1C.

Source files
------------

// File: rtl/pit_pkg.sv
// Programmable interval timer: shared register offsets,
// CTRL bit positions and state encoding.
package pit_pkg;

  localparam logic [1:0] PIT_CTRL   = 2'd0;
  localparam logic [1:0] PIT_LOAD   = 2'd1;
  localparam logic [1:0] PIT_COUNT  = 2'd2;
  localparam logic [1:0] PIT_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_PRESCALE = 8;

  localparam int STATUS_EXPIRED = 0;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } pit_state_e;

endpackage

// File: rtl/pit_prescaler.sv
// Tick divider: one-cycle tick every (divisor+1) clocks while run.
// Ports: clk, rst_n, restart, run, divisor[W], tick.
module pit_prescaler
  import pit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart,
  input  logic         run,
  input  logic [W-1:0] divisor,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  // >= keeps the divider sane if divisor shrinks mid-run.
  assign tick = run & (cnt_q >= divisor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || !run || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pit_timer.sv
// Wishbone PIT: 32-bit down-counter, one-shot/periodic, level irq.
// Ports: clk_i, rst_n_i, wb cyc/stb/we/sel/adr/dat_i, dat_o, ack_o, irq_o.
// Optional PIT_PRESCALER_EN builds the CTRL[15:8] tick prescaler.
module pit_timer
  import pit_pkg::*;
#(
  parameter logic [31:0] RESET_LOAD = 32'd0,
  parameter int          PRESCALE_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        irq_o
);

  pit_state_e state_q, state_d;

  logic        en_q, en_d;
  logic        per_q, per_d;
  logic        ie_q, ie_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        exp_q, exp_d;
  logic        tick;
  logic        start;
  logic [31:0] rdata;

  logic [PRESCALE_W-1:0] presc_q;

  logic unused_bits;
  assign unused_bits = ^{sel_i, adr_i[31:4], adr_i[1:0]};

  logic req, wr;
  logic hit_ctrl, hit_load, hit_count, hit_stat;

  assign req = cyc_i & stb_i & ~ack_o;
  assign wr  = req & we_i;

  assign hit_ctrl  = adr_i[3:2] == PIT_CTRL;
  assign hit_load  = adr_i[3:2] == PIT_LOAD;
  assign hit_count = adr_i[3:2] == PIT_COUNT;
  assign hit_stat  = adr_i[3:2] == PIT_STATUS;

  // Prescaler restarts whenever the timer enters ST_RUN.
  assign start = wr & hit_ctrl & dat_i[CTRL_EN]
               & (state_q == ST_STOP);

`ifdef PIT_PRESCALER_EN
  logic [PRESCALE_W-1:0] presc_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  always_comb begin
    presc_d = presc_q;
    if (wr && hit_ctrl) begin
      presc_d = dat_i[CTRL_PRESCALE +: PRESCALE_W];
    end
  end

  pit_prescaler #(
    .W (PRESCALE_W)
  ) u_presc (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .restart (start),
    .run     (state_q == ST_RUN),
    .divisor (presc_q),
    .tick    (tick)
  );
`else
  assign presc_q = '0;
  assign tick    = (state_q == ST_RUN);
`endif

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    per_d   = per_q;
    ie_d    = ie_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;

    if (wr && hit_ctrl) begin
      en_d  = dat_i[CTRL_EN];
      per_d = dat_i[CTRL_PERIODIC];
      ie_d  = dat_i[CTRL_IE];
    end
    if (wr && hit_load) begin
      load_d = dat_i;
    end
    // W1C first; a same-cycle expiry below overrides it.
    if (wr && hit_stat && dat_i[STATUS_EXPIRED]) begin
      exp_d = 1'b0;
    end

    unique case (state_q)
      ST_STOP: begin
        if (wr && hit_load) begin
          count_d = dat_i;
        end
        if (start) begin
          count_d = load_q;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wr && hit_ctrl && !dat_i[CTRL_EN]) begin
          state_d = ST_STOP;
        end else if (tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else if (count_q == 32'd1) begin
            exp_d = 1'b1;
            if (per_d) begin
              count_d = load_q;
            end else begin
              count_d = '0;
              en_d    = 1'b0;
              state_d = ST_STOP;
            end
          end
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_ctrl: begin
        rdata[CTRL_EN]       = en_q;
        rdata[CTRL_PERIODIC] = per_q;
        rdata[CTRL_IE]       = ie_q;
        rdata[CTRL_PRESCALE +: PRESCALE_W] = presc_q;
      end
      hit_load:  rdata = load_q;
      hit_count: rdata = count_q;
      hit_stat:  rdata[STATUS_EXPIRED] = exp_q;
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_STOP;
      en_q    <= 1'b0;
      per_q   <= 1'b0;
      ie_q    <= 1'b0;
      load_q  <= RESET_LOAD;
      count_q <= RESET_LOAD;
      exp_q   <= 1'b0;
      ack_o   <= 1'b0;
      dat_o   <= '0;
      irq_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      per_q   <= per_d;
      ie_q    <= ie_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      ack_o   <= req;
      if (req && !we_i) begin
        dat_o <= rdata;
      end
      irq_o   <= exp_q & ie_q;
    end
  end

endmodule
